// File: rtl/function_pkg.sv
// Shared constants and types for the serial restore path of the function unit.
package function_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit-counter width for a given operand width (WIDTH >= 2).
   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction

   localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/function_restore_serial_full_adder.sv
// One-bit full adder; add-direction counterpart of full_subtracter.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/function_restore_serial.sv
// Rebuilds a|b = d + b bit-serially (LSB first) and flags operand pairs that
// could not have come out of the function unit (any carry generated).
module function_restore_serial
   import function_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_err
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_n;
   logic [WIDTH-1:0] d_sr, b_sr, acc;
   logic [CW-1:0]    cnt;
   logic             carry, err_sticky;
   logic             sum, cout;
   logic             accept, last;

   full_adder u_fa (
      .a    (d_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (sum),
      .cout (cout)
   );

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE:  if (start) state_n = SHIFT;
         SHIFT: begin
            busy = 1'b1;
            if (last) state_n = DONE;
         end
         DONE:  begin
            done    = 1'b1;
            state_n = start ? SHIFT : IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs only move on the edge into DONE so they hold between operations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_sr       <= '0;
         b_sr       <= '0;
         acc        <= '0;
         cnt        <= '0;
         carry      <= 1'b0;
         err_sticky <= 1'b0;
         result     <= '0;
         carry_err  <= 1'b0;
      end else if (accept) begin
         d_sr       <= d;
         b_sr       <= b;
         acc        <= '0;
         cnt        <= '0;
         carry      <= 1'b0;
         err_sticky <= 1'b0;
      end else if (state == SHIFT) begin
         d_sr       <= {1'b0, d_sr[WIDTH-1:1]};
         b_sr       <= {1'b0, b_sr[WIDTH-1:1]};
         acc        <= {sum, acc[WIDTH-1:1]};
         cnt        <= cnt + CW'(1);
         carry      <= cout;
         err_sticky <= err_sticky | cout;
         if (last) begin
            result    <= {sum, acc[WIDTH-1:1]};
            carry_err <= err_sticky | cout;
         end
      end
   end

endmodule

// File: tb/tb_function_restore_serial.sv
// Directed bench for function_restore_serial with an operation-level reference model.
module tb_function_restore_serial;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] d = '0, b = '0;
   logic         busy, done, carry_err;
   logic [W-1:0] result;

   int vectors = 0;
   int fails   = 0;
   bit chk_en  = 1'b0;

   function_restore_serial #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .d(d), .b(b),
      .busy(busy), .done(done), .result(result), .carry_err(carry_err)
   );

   always #5 clk = ~clk;

   // Reference: an accepted op is busy for W cycles, then one done cycle where
   // result = (d+b) mod 2^W and carry_err = "the sum differs from d^b".
   int           m_left = 0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_res  = '0;
   logic         m_err  = 1'b0;
   logic [W:0]   pd = '0, pb = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_res  <= '0;
         m_err  <= 1'b0;
      end else begin
         m_done <= (m_left == 1);
         if (m_left == 1) begin
            m_res <= W'(pd + pb);
            m_err <= ((pd + pb) != (pd ^ pb));
         end
         if (start && m_left == 0) begin
            m_left <= W;
            pd     <= {1'b0, d};
            pb     <= {1'b0, b};
         end else if (m_left > 0) begin
            m_left <= m_left - 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_busy",   busy,      m_left > 0);
         chk("model_done",   done,      m_done);
         chk("model_result", result,    m_res);
         chk("model_cerr",   carry_err, m_err);
         if (busy && done) chk("busy_and_done", 1'b1, 1'b0);
      end
   end

   task automatic launch(input logic [W-1:0] dd, input logic [W-1:0] bb);
      @(negedge clk);
      d = dd; b = bb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns at the negedge where done is seen; cyc counts negedges since launch.
   task automatic wait_done(output int cyc, output int bcnt);
      cyc = 1; bcnt = 0;
      while (!done && cyc < 60) begin
         if (busy) bcnt++;
         @(negedge clk);
         cyc++;
      end
      if (!done) chk("done_timeout", done, 1'b1);
   endtask

   task automatic op(input string nm, input logic [W-1:0] dd, input logic [W-1:0] bb,
                     input logic [W-1:0] er, input logic ee);
      int cyc, bcnt;
      launch(dd, bb);
      wait_done(cyc, bcnt);
      chk({nm, "_result"}, result, er);
      chk({nm, "_cerr"}, carry_err, ee);
   endtask

   initial begin
      int cyc, bcnt, cyc2;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 8'h00);
      chk("rst_cerr", carry_err, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Basic legal pair plus latency
      launch(8'h52, 8'h0C);
      wait_done(cyc, bcnt);
      chk("lat_busy_cycles", bcnt, 8);
      chk("lat_done_cycle", cyc, 9);
      chk("op1_result", result, 8'h5E);
      chk("op1_cerr", carry_err, 1'b0);

      op("carry_lsb", 8'h01, 8'h01, 8'h02, 1'b1);
      op("carry_msb", 8'hFF, 8'h01, 8'h00, 1'b1);
      op("all_ones",  8'h0F, 8'hF0, 8'hFF, 1'b0);
      op("top_only",  8'h80, 8'h80, 8'h00, 1'b1);

      // Back-to-back: restart from the DONE cycle
      launch(8'hA0, 8'h05);
      wait_done(cyc, bcnt);
      chk("b2b_first_result", result, 8'hA5);
      d = 8'h00; b = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_no_idle_gap", busy, 1'b1);
      wait_done(cyc2, bcnt);
      chk("b2b_done_gap", cyc2, 9);
      chk("b2b_second_result", result, 8'h00);
      chk("b2b_second_cerr", carry_err, 1'b0);

      // Start while busy must be ignored
      launch(8'h33, 8'h44);
      repeat (2) @(negedge clk);
      d = 8'hFF; b = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, bcnt);
      chk("ignore_start_result", result, 8'h77);
      chk("ignore_start_cerr", carry_err, 1'b0);
      @(negedge clk);
      chk("ignore_start_no_second", busy, 1'b0);

      // Reset in the middle of SHIFT
      launch(8'h12, 8'h34);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_result", result, 8'h00);
      chk("midrst_cerr", carry_err, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("midrst_no_done", done, 1'b0);
      end
      op("after_rst", 8'h10, 8'h01, 8'h11, 1'b0);

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
